x2050lsrd: RTL and testbench
============================

// Module: x2050lsrd
// PURPOSE
//  Console/debug read-out engine for 2050 local storage: walks LS words
//  i_first..i_last (inclusive, modulo 64), reads each through the shared LS address
//  path and emits it as 4 bytes on a valid/ready byte stream. Sits beside the LS array
//  as its reader; borrows the LS address mux only while microcode is not advancing.
// PARAMETERS
//  LSA_W      6   LS address width (64 words)
//  MSB_FIRST  1   1: byte 0 sent = bits [31:24]; 0: bits [7:0] first
// PORTS
//  i_clk          in   1      clock, all state on posedge
//  i_reset        in   1      asynchronous reset, ACTIVE-LOW (0 = reset)
//  i_start        in   1      start dump; sampled only in IDLE
//  i_abort        in   1      abandon dump; highest priority after reset
//  i_first        in   LSA_W  first LS address, latched on accepted start
//  i_last         in   LSA_W  last LS address, latched on accepted start
//  i_ros_advance  in   1      microcode advancing this cycle; LS path not ours
//  i_lsa_gnt      in   1      LS address mux granted to this block
//  i_ls           in   32     LS read data (combinational from o_lsa)
//  o_lsa_req      out  1      request for LS address mux
//  o_lsa          out  LSA_W  LS address driven while requesting
//  o_data         out  8      stream byte
//  o_valid        out  1      o_data valid
//  i_ready        in   1      sink accepts byte when o_valid & i_ready
//  o_busy         out  1      dump in progress (state != IDLE)
//  o_done         out  1      one-cycle pulse: last byte of last word accepted
// BEHAVIOUR
//  Reset (i_reset=0): state IDLE; o_lsa_req=0, o_lsa=0, o_data=0, o_valid=0,
//   o_busy=0, o_done=0; internal addr/last/shift/byte count cleared.
//  States: IDLE -> REQ -> SEND -> (REQ | IDLE).
//  IDLE: i_start=1 -> latch addr=i_first, last=i_last; go REQ next cycle.
//  REQ: o_lsa_req=1, o_lsa=addr. Read completes in a cycle with i_lsa_gnt=1 AND
//   i_ros_advance=0: capture i_ls into 32-bit shift reg, byte count=0, go SEND.
//   Otherwise stay in REQ (no timeout). o_lsa held stable throughout REQ.
//  SEND: o_lsa_req=0; o_valid=1, o_data=current byte per MSB_FIRST. o_data/o_valid
//   stable until handshake. On o_valid&i_ready: shift, count+1. When the 4th byte is
//   accepted: if addr==last -> o_done=1 that next cycle, go IDLE; else
//   addr=addr+1 (wraps 63->0), go REQ. Min 1 REQ cycle + 4 SEND cycles per word.
//  Word count = ((last-first) mod 64)+1: first==last -> 1 word; first=62,last=1
//   -> 62,63,0,1; first=last+1 -> all 64 words.
//  i_start while busy: ignored (no relatch). i_start with i_abort: abort wins.
//  i_abort in any non-IDLE state: next cycle IDLE, o_valid=0, o_lsa_req=0, no o_done;
//   partially sent word discarded.
//  Async reset mid-dump: immediate return to reset values; no o_done.
//  Block never writes LS; LS contents unaffected.
// TESTING
//  1. LS[5]=32'h12345678, first=last=5, ready=1 -> bytes 12,34,56,78; o_done once;
//     o_lsa=5 during REQ.
//  2. LS[k]=k*32'h01010101, first=62,last=1 -> addresses 62,63,0,1 in order; 16 bytes;
//     3E x4,3F x4,00 x4,01 x4.
//  3. Hold i_ros_advance=1 for 5 cycles in REQ with gnt=1 -> no capture, o_lsa stable;
//     capture on first cycle with ros_advance=0.
//  4. Random i_ready stalls (~50%) -> o_data unchanged while valid&!ready; byte stream
//     identical to case 1.
//  5. i_abort after 2nd byte of word 2 of a 4-word dump -> IDLE next cycle, valid=0,
//     no o_done; new start then dumps from new i_first correctly.
//  6. Async reset low mid-SEND, and i_start pulsed while busy -> outputs at reset
//     values immediately; busy-time start does not change range.

Source files
------------

// File: rtl/x2050lsrd_if.sv
// LS address-path and byte-stream bundle for the 2050 local-storage dump engine.
// The master side is the dump engine; the slave side is the LS mux plus stream sink.
interface x2050lsrd_if #(
    parameter int LSA_W = 6
);
    logic             o_lsa_req;
    logic [LSA_W-1:0] o_lsa;
    logic             i_lsa_gnt;
    logic             i_ros_advance;
    logic [31:0]      i_ls;
    logic [7:0]       o_data;
    logic             o_valid;
    logic             i_ready;

    modport master (
        output o_lsa_req,
        output o_lsa,
        input  i_lsa_gnt,
        input  i_ros_advance,
        input  i_ls,
        output o_data,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_lsa_req,
        input  o_lsa,
        output i_lsa_gnt,
        output i_ros_advance,
        output i_ls,
        input  o_data,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/x2050lsrd.sv
// 2050 local-storage read-out engine: walks LS words first..last (mod 64)
// and emits each word as four bytes on a valid/ready stream.
module x2050lsrd #(
    parameter int LSA_W     = 6,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [LSA_W-1:0] i_first,
    input  logic [LSA_W-1:0] i_last,
    x2050lsrd_if.master      bus,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SEND
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [LSA_W-1:0] addr;
    logic [LSA_W-1:0] last;
    logic [31:0]      shift;
    logic [1:0]       cnt;
    logic             done_q;

    logic rd_ok;
    logic xfer;
    logic word_end;
    logic [7:0] cur_byte;

    // The LS path is only ours when granted and microcode is not stepping.
    assign rd_ok    = bus.i_lsa_gnt & ~bus.i_ros_advance;
    assign xfer     = bus.o_valid & bus.i_ready;
    assign word_end = xfer & (cnt == 2'd3);
    assign cur_byte = MSB_FIRST ? shift[31:24] : shift[7:0];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (i_start && !i_abort) state_n = REQ;
            end
            REQ: begin
                if (i_abort)    state_n = IDLE;
                else if (rd_ok) state_n = SEND;
            end
            SEND: begin
                if (i_abort)       state_n = IDLE;
                else if (word_end) state_n = (addr == last) ? IDLE : REQ;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.o_lsa_req = (state == REQ);
        bus.o_lsa     = '0;
        bus.o_valid   = (state == SEND);
        bus.o_data    = '0;
        o_busy        = (state != IDLE);
        o_done        = done_q;
        if (state == REQ)  bus.o_lsa  = addr;
        if (state == SEND) bus.o_data = cur_byte;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            addr   <= '0;
            last   <= '0;
            shift  <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_start && !i_abort) begin
                        addr <= i_first;
                        last <= i_last;
                    end
                end
                REQ: begin
                    if (!i_abort && rd_ok) begin
                        shift <= bus.i_ls;
                        cnt   <= '0;
                    end
                end
                SEND: begin
                    if (!i_abort && xfer) begin
                        shift <= MSB_FIRST ? (shift << 8) : (shift >> 8);
                        cnt   <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            if (addr == last) done_q <= 1'b1;
                            else              addr   <= addr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_x2050lsrd.sv
// Randomised bench for x2050lsrd: LS array and expected byte/address
// queues are derived from the dump range, then checked at each handshake.
module tb_x2050lsrd;

    logic       i_clk;
    logic       i_reset;
    logic       i_start;
    logic       i_abort;
    logic [5:0] i_first;
    logic [5:0] i_last;
    logic       o_busy;
    logic       o_done;

    x2050lsrd_if #(.LSA_W(6)) bus ();

    x2050lsrd #(.LSA_W(6), .MSB_FIRST(1'b1)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_abort (i_abort),
        .i_first (i_first),
        .i_last  (i_last),
        .bus     (bus.master),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    logic [31:0] mem [64];
    assign bus.i_ls = mem[bus.o_lsa];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    logic [5:0] aq[$];
    bit         m_busy;
    bit         m_done_next;
    int         m_acc;
    bit         prev_stall;
    logic [7:0] prev_data;
    bit         prev_reqwait;
    logic [5:0] prev_lsa;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit rnd(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic clear_model();
        exp_q.delete();
        aq.delete();
        m_busy       = 1'b0;
        m_done_next  = 1'b0;
        prev_stall   = 1'b0;
        prev_reqwait = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_valid"}, bus.o_valid, 0);
        check({tag, "_req"}, bus.o_lsa_req, 0);
        check({tag, "_lsa"}, bus.o_lsa, 0);
        check({tag, "_data"}, bus.o_data, 0);
    endtask

    // One cycle: check outputs at the falling edge, drive inputs, and
    // predict what the next rising edge will transfer.
    task automatic step(input bit rdy, input bit gnt, input bit ros,
                        input bit abt, input bit st,
                        input logic [5:0] f, input logic [5:0] l);
        logic [31:0] w;
        logic [5:0]  span;
        logic [5:0]  a;
        @(negedge i_clk);
        check("busy", o_busy, m_busy);
        check("done", o_done, m_done_next);
        m_done_next = 1'b0;
        if (!m_busy) begin
            check("idle_valid", bus.o_valid, 0);
            check("idle_req", bus.o_lsa_req, 0);
        end
        if (prev_stall) begin
            check("stall_valid", bus.o_valid, 1);
            check("stall_data", bus.o_data, prev_data);
        end
        if (prev_reqwait) begin
            check("req_hold", bus.o_lsa_req, 1);
            check("lsa_hold", bus.o_lsa, prev_lsa);
        end
        bus.i_ready       = rdy;
        bus.i_lsa_gnt     = gnt;
        bus.i_ros_advance = ros;
        i_abort           = abt;
        i_start           = st;
        i_first           = f;
        i_last            = l;
        prev_stall   = bus.o_valid & !rdy & !abt;
        prev_data    = bus.o_data;
        prev_reqwait = bus.o_lsa_req & !(gnt & !ros) & !abt;
        prev_lsa     = bus.o_lsa;
        if (abt) begin
            exp_q.delete();
            aq.delete();
            m_busy = 1'b0;
        end else if (!m_busy && st) begin
            span  = l - f;
            m_acc = 0;
            for (int k = 0; k <= int'(span); k++) begin
                a = f + 6'(k);
                aq.push_back(a);
                w = mem[a];
                for (int b = 0; b < 4; b++)
                    exp_q.push_back(8'(w >> (24 - 8 * b)));
            end
            m_busy = 1'b1;
        end else if (m_busy) begin
            if (bus.o_lsa_req && gnt && !ros) begin
                if (aq.size() == 0) check("addr_underrun", 1, 0);
                else check("lsa", bus.o_lsa, aq.pop_front());
            end
            if (bus.o_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    check("byte_underrun", 1, 0);
                end else begin
                    check("byte", bus.o_data, exp_q.pop_front());
                    m_acc++;
                    if (exp_q.size() == 0) begin
                        m_busy      = 1'b0;
                        m_done_next = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic hard_reset();
        @(negedge i_clk);
        i_reset = 1'b0;
        clear_model();
        @(negedge i_clk);
        i_reset = 1'b1;
    endtask

    task automatic start_dump(input logic [5:0] f, input logic [5:0] l);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, f, l);
    endtask

    task automatic run(input int pr_rdy, input int pr_gnt, input int pr_ros,
                       input int abort_after, input bit busy_start);
        bit abt;
        for (int n = 0; n < 4000 && m_busy; n++) begin
            abt = (abort_after >= 0) && (m_acc == abort_after);
            step(rnd(pr_rdy), rnd(pr_gnt), rnd(pr_ros), abt,
                 busy_start && rnd(10), 6'($urandom), 6'($urandom));
        end
        if (m_busy) begin
            check("timeout", 0, 1);
            hard_reset();
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
    endtask

    initial begin
        i_reset           = 1'b0;
        i_start           = 1'b0;
        i_abort           = 1'b0;
        i_first           = '0;
        i_last            = '0;
        bus.i_ready       = 1'b0;
        bus.i_lsa_gnt     = 1'b0;
        bus.i_ros_advance = 1'b0;
        m_acc             = 0;
        clear_model();
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        #1;
        check_reset_vals("rst");
        @(negedge i_clk);
        i_reset = 1'b1;

        // Single word, always ready
        mem[5] = 32'h12345678;
        start_dump(6'd5, 6'd5);
        run(100, 100, 0, -1, 1'b0);

        // Wrap-around range
        for (int i = 0; i < 64; i++) mem[i] = 32'(i) * 32'h01010101;
        start_dump(6'd62, 6'd1);
        run(100, 100, 0, -1, 1'b0);

        // Microcode holding the LS path for five cycles
        mem[5] = 32'h12345678;
        start_dump(6'd5, 6'd5);
        repeat (5) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
        run(100, 100, 0, -1, 1'b0);

        // Sink stalls
        start_dump(6'd5, 6'd5);
        run(50, 100, 0, -1, 1'b0);

        // Abort after the second byte of word 2, then a fresh dump
        start_dump(6'd8, 6'd11);
        run(100, 100, 0, 6, 1'b0);
        start_dump(6'd40, 6'd42);
        run(70, 80, 20, -1, 1'b0);

        // Asynchronous reset while in SEND with the sink stalled
        start_dump(6'd10, 6'd13);
        for (int n = 0; n < 20 && !bus.o_valid; n++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
        @(posedge i_clk);
        #2 i_reset = 1'b0;
        #1 check_reset_vals("async");
        clear_model();
        @(negedge i_clk);
        i_reset = 1'b1;
        start_dump(6'd20, 6'd21);
        run(60, 70, 30, -1, 1'b1);

        // Randomised ranges, LS contents and handshakes
        for (int t = 0; t < 12; t++) begin
            logic [5:0] f;
            for (int i = 0; i < 64; i++) mem[i] = $urandom;
            f = 6'($urandom);
            start_dump(f, f + 6'($urandom_range(5)));
            run(int'($urandom_range(30, 100)), 70, 25,
                rnd(20) ? int'($urandom_range(8)) : -1, 1'b1);
        end

        // Every word: first = last + 1
        start_dump(6'd33, 6'd32);
        run(60, 80, 20, -1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
